// File: rtl/gb_rom_loader_if.sv
// Byte stream in from the host bridge and word-wide ioctl bus out to the cartridge block.
// The loader is the master; the bridge/cartridge side is the slave.
interface gb_rom_loader_if #(
    parameter int unsigned ADDR_W = 25
) ();
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              cart_download;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              ioctl_wait;

    modport master (
        input  s_data, s_valid, ioctl_wait,
        output s_ready, cart_download, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout
    );

    modport slave (
        output s_data, s_valid, ioctl_wait,
        input  s_ready, cart_download, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout
    );
endinterface

// File: rtl/gb_rom_loader.sv
// Cartridge download initiator: packs a ROM byte stream into little-endian 16-bit
// ioctl words, pads an odd tail, honours ioctl_wait and reports the final image size.
module gb_rom_loader #(
    parameter int unsigned ADDR_W   = 25,
    parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rom_len,
    input  logic              abort,
    output logic [63:0]       img_size,
    output logic              busy,
    output logic              done,
    gb_rom_loader_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_HOLD,
        ST_WAIT,
        ST_FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] commit_q, commit_d;
    logic [15:0]       dout_q, dout_d;
    logic              abort_q, abort_d;
    logic [63:0]       img_size_q, img_size_d;
    logic              s_ready_q, s_ready_d;
    logic              dl_q, dl_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abort_pend;

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            commit_q   <= '0;
            dout_q     <= '0;
            abort_q    <= 1'b0;
            img_size_q <= '0;
            s_ready_q  <= 1'b0;
            dl_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            commit_q   <= commit_d;
            dout_q     <= dout_d;
            abort_q    <= abort_d;
            img_size_q <= img_size_d;
            s_ready_q  <= s_ready_d;
            dl_q       <= dl_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; outputs are derived from the next state
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        commit_d   = commit_q;
        dout_d     = dout_q;
        abort_d    = abort_q;
        img_size_d = img_size_q;
        done_d     = 1'b0;
        abort_pend = abort_q | abort;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (rom_len != '0) begin
                        len_d    = rom_len;
                        cnt_d    = '0;
                        addr_d   = '0;
                        commit_d = '0;
                        abort_d  = 1'b0;
                        state_d  = ST_LO;
                    end else begin
                        img_size_d = '0;
                        done_d     = 1'b1;
                    end
                end
            end
            ST_LO: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (bus.s_valid) begin
                    dout_d[7:0] = bus.s_data;
                    cnt_d       = cnt_q + ADDR_W'(1);
                    if (cnt_q + ADDR_W'(1) == len_q) begin
                        dout_d[15:8] = PAD_BYTE;
                        state_d      = ST_WRITE;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (bus.s_valid) begin
                    dout_d[15:8] = bus.s_data;
                    cnt_d        = cnt_q + ADDR_W'(1);
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                commit_d = cnt_q;
                abort_d  = abort_pend;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                abort_d = abort_pend;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                abort_d = abort_pend;
                if (!bus.ioctl_wait) begin
                    if ((cnt_q < len_q) && !abort_pend) begin
                        addr_d  = addr_q + ADDR_W'(2);
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only whole words count: an abort in LO/HI drops the partial word
        if (state_d == ST_FINISH) begin
            img_size_d = 64'(commit_q);
            done_d     = 1'b1;
        end

        s_ready_d = (state_d == ST_LO) || (state_d == ST_HI);
        busy_d    = (state_d != ST_IDLE);
        dl_d      = busy_d && (state_d != ST_FINISH);
        wr_d      = (state_d == ST_WRITE);
    end

    // abort must win over a same-cycle byte, so it masks the registered ready
    assign bus.s_ready        = s_ready_q & ~abort;
    assign bus.cart_download  = dl_q;
    assign bus.ioctl_download = dl_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign img_size           = img_size_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_gb_rom_loader.sv
// Scoreboard bench for gb_rom_loader: directed transfers push expected strobes/dones,
// a negedge monitor pops and compares them and checks the ioctl protocol.
module tb_gb_rom_loader;
    localparam int unsigned AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rom_len;
    logic          abort;
    logic [63:0]   img_size;
    logic          busy;
    logic          done;

    gb_rom_loader_if #(.ADDR_W(AW)) bus ();

    gb_rom_loader #(.ADDR_W(AW), .PAD_BYTE(8'hFF)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .rom_len  (rom_len),
        .abort    (abort),
        .img_size (img_size),
        .busy     (busy),
        .done     (done),
        .bus      (bus.master)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    logic [AW+15:0] exp_wr[$];
    logic [63:0]    exp_done[$];
    int             wr_cnt = 0;
    int             done_cnt = 0;
    int             stall_len = 0;
    int             wait_cnt = 0;
    bit             dl_seen = 0;
    logic           prev_wr = 1'b0;
    logic           prev_wait = 1'b0;
    logic [AW-1:0]  lat_addr = '0;
    logic [15:0]    lat_dout = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cartridge model: ioctl_wait rises one cycle after a strobe for stall_len cycles
    initial begin
        bus.ioctl_wait = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (wait_cnt > 0) begin
                bus.ioctl_wait = 1'b1;
                wait_cnt--;
            end else begin
                bus.ioctl_wait = 1'b0;
            end
            if (bus.ioctl_wr) wait_cnt = stall_len;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk_sys) begin
        logic [AW+15:0] ew;
        if (bus.cart_download) dl_seen = 1;
        if (bus.ioctl_wr) begin
            wr_cnt++;
            chk("wr_spacing_and_wait", {62'd0, prev_wr, prev_wait}, 64'd0);
            if (exp_wr.size() == 0) begin
                chk("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                ew = exp_wr.pop_front();
                chk("strobe_addr", 64'(bus.ioctl_addr), 64'(ew[AW+15:16]));
                chk("strobe_dout", 64'(bus.ioctl_dout), 64'(ew[15:0]));
            end
            lat_addr = bus.ioctl_addr;
            lat_dout = bus.ioctl_dout;
        end else if (bus.ioctl_wait && bus.cart_download) begin
            chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
            chk("stall_addr", 64'(bus.ioctl_addr), 64'(lat_addr));
            chk("stall_dout", 64'(bus.ioctl_dout), 64'(lat_dout));
        end
        if (bus.ioctl_download !== bus.cart_download)
            chk("ioctl_download_copy", 64'(bus.ioctl_download), 64'(bus.cart_download));
        if (done) begin
            done_cnt++;
            chk("done_cart_download", 64'(bus.cart_download), 64'd0);
            chk("done_after_wait_low", 64'(prev_wait), 64'd0);
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("img_size", img_size, exp_done.pop_front());
            end
        end
        prev_wr   = bus.ioctl_wr;
        prev_wait = bus.ioctl_wait;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        rom_len = AW'(len);
        tick(1);
        start   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit got = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk_sys);
            if (bus.s_ready) got = 1;
        end
        if (!got) chk("send_timeout", 64'd1, 64'd0);
        tick(1);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit got = 0;
        for (int n = 0; n < 1000 && !got; n++) begin
            tick(1);
            if (done_cnt >= target) got = 1;
        end
        if (!got) chk("done_timeout", 64'd1, 64'd0);
        tick(2);
    endtask

    task automatic push_wr(input int addr, input logic [15:0] d);
        exp_wr.push_back({AW'(addr), d});
    endtask

    initial begin
        int tgt;
        bit got;
        reset       = 1'b1;
        start       = 1'b0;
        rom_len     = '0;
        abort       = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_outputs", {img_size[31:0], 24'd0, bus.s_ready, bus.cart_download,
            bus.ioctl_download, bus.ioctl_wr, busy, done, 2'b00}, 64'd0);
        chk("rst_addr_dout", {23'd0, bus.ioctl_addr, bus.ioctl_dout}, 64'd0);
        tick(1);

        // Length 4, no stall
        push_wr(0, 16'hCE31); push_wr(2, 16'h66ED); exp_done.push_back(64'd4);
        tgt = done_cnt + 1;
        do_start(4);
        chk("start_cart_download", 64'(bus.cart_download), 64'd1);
        chk("start_s_ready", 64'(bus.s_ready), 64'd1);
        send(8'h31); send(8'hCE); send(8'hED); send(8'h66);
        wait_done(tgt);

        // Length 3, odd tail padded
        push_wr(0, 16'h2211); push_wr(2, 16'hFF33); exp_done.push_back(64'd3);
        tgt = done_cnt + 1;
        do_start(3);
        send(8'h11); send(8'h22); send(8'h33);
        wait_done(tgt);

        // Stalled cartridge, lengths 4 and 2
        stall_len = 10;
        push_wr(0, 16'hA2A1); push_wr(2, 16'hA4A3); exp_done.push_back(64'd4);
        tgt = done_cnt + 1;
        do_start(4);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        wait_done(tgt);
        push_wr(0, 16'hC35A); exp_done.push_back(64'd2);
        tgt = done_cnt + 1;
        do_start(2);
        send(8'h5A); send(8'hC3);
        wait_done(tgt);
        stall_len = 0;
        tick(12);

        // Length 8 with a source gap before the fourth byte
        push_wr(0, 16'h1110); push_wr(2, 16'h1312); push_wr(4, 16'h1514);
        push_wr(6, 16'h1716); exp_done.push_back(64'd8);
        tgt = done_cnt + 1;
        do_start(8);
        send(8'h10); send(8'h11); send(8'h12);
        wr_cnt = 0;
        tick(5);
        chk("gap_no_strobe", 64'(wr_cnt), 64'd0);
        send(8'h13); send(8'h14); send(8'h15); send(8'h16); send(8'h17);
        wait_done(tgt);

        // Abort in HI after 5 bytes, then a fresh transfer
        push_wr(0, 16'h0201); push_wr(2, 16'h0403); exp_done.push_back(64'd4);
        tgt = done_cnt + 1;
        do_start(8);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done(tgt);
        push_wr(0, 16'hBBAA); exp_done.push_back(64'd2);
        tgt = done_cnt + 1;
        do_start(2);
        send(8'hAA); send(8'hBB);
        wait_done(tgt);

        // Reset while in WAIT
        stall_len = 10;
        push_wr(0, 16'h0201);
        do_start(4);
        send(8'h01); send(8'h02);
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            tick(1);
            if (bus.ioctl_wait) got = 1;
        end
        if (!got) chk("wait_rise_timeout", 64'd1, 64'd0);
        tick(2);
        tgt = done_cnt;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("midrst_outputs", {img_size[31:0], 24'd0, bus.s_ready, bus.cart_download,
            bus.ioctl_download, bus.ioctl_wr, busy, done, 2'b00}, 64'd0);
        chk("midrst_addr_dout", {23'd0, bus.ioctl_addr, bus.ioctl_dout}, 64'd0);
        stall_len = 0;
        tick(20);
        chk("midrst_no_done", 64'(done_cnt), 64'(tgt));
        push_wr(0, 16'h8877); exp_done.push_back(64'd2);
        tgt = done_cnt + 1;
        do_start(2);
        send(8'h77); send(8'h88);
        wait_done(tgt);

        // Zero-length start
        dl_seen = 0;
        exp_done.push_back(64'd0);
        tgt = done_cnt + 1;
        do_start(0);
        wait_done(tgt);
        chk("zero_len_no_download", 64'(dl_seen), 64'd0);

        chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("exp_done_drained", 64'(exp_done.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gb_rom_loader.md
# gb_rom_loader

Initiator side of the cartridge download interface: accepts a byte stream of a ROM image from the host data-slot bridge and drives `cart_download`/`ioctl_download`, `ioctl_wr`, `ioctl_addr` and `ioctl_dout` into the cartridge block. It honours that block's `ioctl_wait` back-pressure. It packs bytes little-endian into 16-bit words, pads an odd tail, and reports the final image size. It sits between the bridge FIFO and `cart_top`, in the `clk_sys` domain.

## Interface
- `ADDR_W`, 25: byte-address and length width.
- `PAD_BYTE`, 8'hFF: fill for the high byte of a final odd word.
- `clk_sys` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a transfer; ignored unless in IDLE.
- `rom_len` in ADDR_W: image length in bytes, sampled on an accepted `start`.
- `abort` in 1: terminate the current transfer.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte when `s_valid & s_ready`.
- `cart_download` out 1: high for the whole transfer.
- `ioctl_download` out 1: identical copy of `cart_download`.
- `ioctl_wr` out 1: one-cycle word strobe.
- `ioctl_addr` out ADDR_W: even byte address of the current word.
- `ioctl_dout` out 16: [7:0] = byte at the even address, [15:8] = byte at the odd address.
- `ioctl_wait` in 1: cartridge busy; it rises one cycle after `ioctl_wr`.
- `img_size` out 64: count of bytes written, zero-extended; valid from `done`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer, including an aborted transfer.

## Operation
- States are IDLE, LO, HI, WRITE, HOLD, WAIT, FINISH.
- IDLE:
  - `start` with `rom_len != 0` latches the length, clears the address and the byte counter, sets `cart_download`, and moves to LO.
  - `start` with `rom_len == 0` pulses `done` with `img_size = 0`; `cart_download` stays low.
- LO:
  - `s_ready = 1`. The accepted byte goes to `ioctl_dout[7:0]` and the counter increments.
  - If the counter reaches `rom_len`, load `ioctl_dout[15:8] = PAD_BYTE` and go to WRITE. Otherwise go to HI.
- HI:
  - `s_ready = 1`. The accepted byte goes to `ioctl_dout[15:8]`, the counter increments, and the state moves to WRITE.
- WRITE: `ioctl_wr = 1` for exactly one cycle, then HOLD.
- HOLD: one cycle that covers the one-cycle lag in `ioctl_wait`, then WAIT.
- WAIT:
  - Stay while `ioctl_wait = 1`.
  - When it is 0: if the counter is below `rom_len`, `ioctl_addr += 2` and go to LO. Otherwise go to FINISH.
- FINISH: clears `cart_download`, pulses `done`, sets `img_size` to the counter, and returns to IDLE.
- `s_ready = 0` in every state except LO and HI.
- `ioctl_addr` and `ioctl_dout` hold stable from WRITE through WAIT.
- `abort`:
  - In LO or HI: go to FINISH without a partial write. `img_size` equals the bytes contained in completed words.
  - In WRITE, HOLD or WAIT: the word completes normally, then the state goes to FINISH.
  - `abort` has priority over byte acceptance in the same cycle.
- `start` while `busy` is ignored.
- The counter and address are ADDR_W bits wide. `rom_len <= 2^ADDR_W - 1`, so the counter and address never wrap.

## Timing
- Reset values: state IDLE, and all outputs 0. This includes `s_ready`, `cart_download`, `ioctl_download`, `ioctl_wr`, `ioctl_addr`, `ioctl_dout`, `img_size`, `busy` and `done`.
- A reset asserted mid-transfer forces these values on the next edge, without a `done` pulse.
- `start` to `cart_download` high: 1 cycle. The first `s_ready` comes in the same cycle as `cart_download`.
- Minimum word period with no stall: 5 cycles (LO, HI, WRITE, HOLD, WAIT with `ioctl_wait = 0`). Minimum gap between `ioctl_wr` pulses: 4 cycles.
- `ioctl_wr` is never asserted while `ioctl_wait = 1`, and never in the cycle immediately after a previous `ioctl_wr`.
- `cart_download` falls 1 cycle after the final WAIT exit, in the same cycle as `done`. At least one cycle of `ioctl_wait = 0` is seen after the last strobe.

## Test plan
- Length 4, bytes 31 CE ED 66, no stall -> two strobes:
  - `addr = 0`, `dout = 16'hCE31`;
  - `addr = 2`, `dout = 16'h66ED`;
  - then `done`, with `img_size = 4` and `cart_download` low.
- Length 3, bytes 11 22 33 -> second word is `addr = 2`, `dout = 16'hFF33`; `img_size = 3`.
- Length 2 with the stall stimulus below -> `ioctl_addr`/`ioctl_dout` stay stable, and no second strobe occurs until 1 cycle after `ioctl_wait` falls.
  - Stall stimulus: the bench holds `ioctl_wait` high for 10 cycles after each strobe.
  - Also check: `s_ready = 0` throughout the stall.
- Length 8, bench pulls `s_valid` low for 5 cycles between bytes 2 and 3 -> no strobe is issued until byte 3 is accepted; the data sequence is intact.
- Abort:
  - Stimulus: `abort` in HI after 5 bytes of a length-8 image.
  - Response: exactly two strobes, at 0 and 2; `done` with `img_size = 4`; `cart_download` low.
  - Then a `start` with length 2 -> a fresh transfer from `addr = 0`.
- Reset mid-WAIT -> all outputs 0 on the next cycle and no `done`. A later `start` with length 2 -> one strobe at `addr = 0`.
- `start` with length 0 -> a `done` pulse, `img_size = 0`, `cart_download` never high.
